// File: rtl/ring_stop_buffered_pkg.sv
// rtl/ring_stop_buffered_pkg.sv - shared defaults and types for the buffered ring stop
// Purpose: default parameter values and the output-slot selection type.
// Ports: none (package).
package ring_stop_buffered_pkg;

  localparam int DEF_FLIT_W    = 144;
  localparam int DEF_ID_W      = 4;
  localparam int DEF_VALID_BIT = 12;
  localparam int DEF_MY_ID     = 0;
  localparam int DEF_EJ_DEPTH  = 4;
  localparam int DEF_CNT_W     = 16;

  // What the outgoing ring slot carries next cycle.
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FWD   = 2'd1,
    SLOT_INJ   = 2'd2
  } slot_sel_e;

endpackage

// File: rtl/ring_eject_fifo.sv
// rtl/ring_eject_fifo.sv - synchronous ejection FIFO for the ring stop
// Purpose: holds flits ejected at this node until the sink can take them.
// Ports: clk, rst (sync, active-high), wr_en/wr_data (tail write),
//        rd_en/rd_data (head pop, rd_data is always the head),
//        count/full/empty (occupancy status).
module ring_eject_fifo #(
  parameter int W     = 144,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/ring_stop_buffered.sv
// rtl/ring_stop_buffered.sv - one buffered hop of a unidirectional ring
// Purpose: registers the ring flit, ejects flits for MY_ID into a FIFO,
//          deflects them when the FIFO is full, injects into free slots.
// Ports: clk, rst (sync, active-high); port_in/port_out ring flits;
//        inj/accept local injection; eject/push/bfull ejection sink;
//        defl_cnt saturating deflection count.
module ring_stop_buffered
  import ring_stop_buffered_pkg::*;
#(
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int ID_W      = DEF_ID_W,
  parameter int VALID_BIT = DEF_VALID_BIT,
  parameter int MY_ID     = DEF_MY_ID,
  parameter int EJ_DEPTH  = DEF_EJ_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] port_in,
  input  logic [FLIT_W-1:0] inj,
  input  logic              bfull,
  output logic [FLIT_W-1:0] port_out,
  output logic              accept,
  output logic [FLIT_W-1:0] eject,
  output logic              push,
  output logic [CNT_W-1:0]  defl_cnt
);

  localparam int CW = $clog2(EJ_DEPTH) + 1;

  logic              in_v;
  logic              local_hit;
  logic              wr_ok;
  logic              written;
  logic              deflect;
  logic              slot_free;
  logic [FLIT_W-1:0] head;
  logic [CW-1:0]     ej_count;
  logic              ej_full_unused;
  logic              ej_empty;
  slot_sel_e         slot_sel;

  assign in_v      = port_in[VALID_BIT];
  assign local_hit = in_v & (port_in[ID_W-1:0] == ID_W'(MY_ID));

  assign push  = ~rst & ~ej_empty & ~bfull;
  assign eject = push ? head : '0;

  // Room exists below depth, or at depth when the head leaves this cycle.
  assign wr_ok     = (ej_count < CW'(EJ_DEPTH)) | push;
  assign written   = ~rst & local_hit & wr_ok;
  assign deflect   = ~rst & local_hit & ~wr_ok;
  assign slot_free = ~in_v | written;
  assign accept    = ~rst & inj[VALID_BIT] & slot_free;

  ring_eject_fifo #(
    .W     (FLIT_W),
    .DEPTH (EJ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (written),
    .wr_data (port_in),
    .rd_en   (push),
    .rd_data (head),
    .count   (ej_count),
    .full    (ej_full_unused),
    .empty   (ej_empty)
  );

  always_comb begin
    slot_sel = SLOT_EMPTY;
    if (accept)                slot_sel = SLOT_INJ;
    else if (in_v & ~written)  slot_sel = SLOT_FWD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_out <= '0;
      defl_cnt <= '0;
    end else begin
      case (slot_sel)
        SLOT_INJ: port_out <= inj;
        SLOT_FWD: port_out <= port_in;
        default:  port_out <= '0;
      endcase
      if (deflect && (defl_cnt != {CNT_W{1'b1}}))
        defl_cnt <= defl_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_stop_buffered.sv
// tb/tb_ring_stop_buffered.sv - directed table-driven bench for ring_stop_buffered
module tb_ring_stop_buffered;

  localparam int FW = 144;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] port_in;
  logic [FW-1:0] inj;
  logic          bfull;
  logic [FW-1:0] port_out;
  logic          accept;
  logic [FW-1:0] eject;
  logic          push;
  logic [15:0]   defl_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ring_stop_buffered #(
    .FLIT_W(144), .ID_W(4), .VALID_BIT(12), .MY_ID(5), .EJ_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .port_in(port_in), .inj(inj), .bfull(bfull),
    .port_out(port_out), .accept(accept), .eject(eject), .push(push),
    .defl_cnt(defl_cnt)
  );

  typedef struct {
    logic          rst;
    logic [FW-1:0] pin;
    logic [FW-1:0] inj;
    logic          bfull;
    logic          e_acc;
    logic          e_push;
    logic [FW-1:0] e_ej;
    logic [FW-1:0] e_out;
    logic [15:0]   e_defl;
  } vec_t;

  vec_t vecs[$];

  // Flits: dest in [3:0], src in [7:4], valid at bit 12.
  localparam logic [FW-1:0] Z  = '0;
  localparam logic [FW-1:0] T  = 144'h1857;   // dest 7, src 5
  localparam logic [FW-1:0] T2 = 144'h1867;   // dest 7, src 6
  localparam logic [FW-1:0] L  = 144'h1875;   // dest 5, src 7
  localparam logic [FW-1:0] A1 = 144'h11015;
  localparam logic [FW-1:0] A2 = 144'h21025;
  localparam logic [FW-1:0] A3 = 144'h31035;
  localparam logic [FW-1:0] A4 = 144'h41045;
  localparam logic [FW-1:0] A5 = 144'h51055;

  task automatic add(input logic r, input logic [FW-1:0] p, input logic [FW-1:0] i,
                     input logic b, input logic ea, input logic ep,
                     input logic [FW-1:0] ee, input logic [FW-1:0] eo,
                     input logic [15:0] ed);
    vec_t v;
    v.rst = r; v.pin = p; v.inj = i; v.bfull = b; v.e_acc = ea; v.e_push = ep;
    v.e_ej = ee; v.e_out = eo; v.e_defl = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [FW-1:0] p, input logic [FW-1:0] i,
                       input logic b);
    rst = r; port_in = p; inj = i; bfull = b;
  endtask

  initial begin
    int pushes;
    //   rst pin  inj bf | acc push eject out  defl
    add(1, L,  T,  0,   0, 0, Z,  Z,  0);   // reset gating
    add(0, Z,  T,  0,   1, 0, Z,  T,  0);   // inject into empty slot
    add(0, L,  Z,  0,   0, 0, Z,  Z,  0);   // eject: slot freed
    add(0, Z,  Z,  0,   0, 1, L,  Z,  0);   // pushed next cycle
    add(0, T,  T2, 0,   0, 0, Z,  T,  0);   // transit blocks inject
    add(0, L,  T2, 0,   1, 0, Z,  T2, 0);   // slot reuse
    add(0, Z,  Z,  0,   0, 1, L,  Z,  0);
    add(0, A1, Z,  1,   0, 0, Z,  Z,  0);   // fill under bfull
    add(0, A2, Z,  1,   0, 0, Z,  Z,  0);
    add(0, A3, Z,  1,   0, 0, Z,  Z,  0);
    add(0, A4, Z,  1,   0, 0, Z,  Z,  0);
    add(0, A5, Z,  1,   0, 0, Z,  A5, 1);   // deflected
    add(0, Z,  Z,  0,   0, 1, A1, Z,  1);   // drain in order
    add(0, Z,  Z,  0,   0, 1, A2, Z,  1);
    add(0, Z,  Z,  0,   0, 1, A3, Z,  1);
    add(0, Z,  Z,  0,   0, 1, A4, Z,  1);
    add(0, Z,  Z,  0,   0, 0, Z,  Z,  1);
    add(0, A1, Z,  1,   0, 0, Z,  Z,  1);   // refill
    add(0, A2, Z,  1,   0, 0, Z,  Z,  1);
    add(0, A3, Z,  1,   0, 0, Z,  Z,  1);
    add(0, A4, Z,  1,   0, 0, Z,  Z,  1);
    add(0, A5, T,  0,   1, 1, A1, T,  1);   // full + pop: stored, slot reused
    add(0, Z,  Z,  0,   0, 1, A2, Z,  1);
    add(0, Z,  Z,  0,   0, 1, A3, Z,  1);
    add(0, Z,  Z,  0,   0, 1, A4, Z,  1);
    add(0, Z,  Z,  0,   0, 1, A5, Z,  1);
    add(0, Z,  Z,  0,   0, 0, Z,  Z,  1);
    add(0, A1, Z,  1,   0, 0, Z,  Z,  1);   // two held, then reset
    add(0, A2, T,  1,   1, 0, Z,  T,  1);
    add(1, L,  T,  0,   0, 0, Z,  Z,  0);
    add(0, Z,  Z,  0,   0, 0, Z,  Z,  0);   // contents discarded
    add(0, L,  Z,  0,   0, 0, Z,  Z,  0);
    add(0, Z,  Z,  0,   0, 1, L,  Z,  0);
    add(0, Z,  L,  0,   1, 0, Z,  L,  0);   // self-addressed inject goes to ring
    add(0, Z,  Z,  0,   0, 0, Z,  Z,  0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].pin, vecs[k].inj, vecs[k].bfull);
      #4;
      chk($sformatf("v%0d accept", k), FW'(accept), FW'(vecs[k].e_acc));
      chk($sformatf("v%0d push", k),   FW'(push),   FW'(vecs[k].e_push));
      chk($sformatf("v%0d eject", k),  eject,       vecs[k].e_ej);
      @(posedge clk); #1;
      chk($sformatf("v%0d port_out", k), port_out,      vecs[k].e_out);
      chk($sformatf("v%0d defl_cnt", k), FW'(defl_cnt), FW'(vecs[k].e_defl));
    end

    // Hand sequence: six locals under bfull -> two deflections, then drain four.
    for (int k = 0; k < 6; k++) begin
      drive(0, A1 + (FW'(k) << 20), Z, 1);
      @(posedge clk); #1;
    end
    drive(0, Z, Z, 1);
    #4;
    chk("hs push held by bfull", FW'(push), FW'(0));
    chk("hs defl two", FW'(defl_cnt), FW'(2));
    @(posedge clk); #1;
    bfull = 0;
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      #4;
      if (push) begin
        chk($sformatf("hs drain %0d", pushes), eject, A1 + (FW'(pushes) << 20));
        pushes++;
      end
      @(posedge clk); #1;
    end
    chk("hs drain count", FW'(pushes), FW'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
